// File: rtl/set24_time_controller.sv
// set24_time_controller
//   Keeps a 24-hour HH:MM:SS time of day from the system clock. It also runs
//   the set-time FSM (RUN -> SET_H -> SET_M -> RUN) from debounced one-cycle
//   button pulses. After TIMEOUT_S seconds with no button activity in a set
//   state, the edit is committed and the block returns to RUN.
//
// Parameters
//   CLK_HZ     clock frequency in Hz (multiple of 4, >= 8)
//   TIMEOUT_S  idle seconds in a set state before returning to RUN (1..63)
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   btn_mode       one-cycle pulse, advance the set-mode FSM
//   btn_up         one-cycle pulse, increment the edited field
//   btn_down       one-cycle pulse, decrement the edited field
//   current_state  0 = RUN, 1 = SET_H, 2 = SET_M
//   real_quarter   blink phase, 1 = edited digits visible
//   hours          0..23
//   minutes        0..59
//   seconds        0..59
//   sec_tick       one-cycle pulse on each 1 s boundary
module set24_time_controller #(
  parameter int CLK_HZ    = 1000000,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] current_state,
  output logic       real_quarter,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick
);

  localparam int Q  = CLK_HZ / 4;
  localparam int PW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(Q - 1);
  localparam logic [5:0]    TO_LAST  = 6'(TIMEOUT_S - 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SET_H = 2'd1;
  localparam logic [1:0] ST_SET_M = 2'd2;

  logic [1:0]    r_state;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_quarter;
  logic          r_real_quarter;
  logic [4:0]    r_hours;
  logic [5:0]    r_minutes;
  logic [5:0]    r_seconds;
  logic          r_sec_tick;
  logic [5:0]    r_timeout;

  logic [1:0]    w_state_next;
  logic [PW-1:0] w_pre_next;
  logic [1:0]    w_quarter_next;
  logic          w_real_quarter_next;
  logic [4:0]    w_hours_next;
  logic [5:0]    w_minutes_next;
  logic [5:0]    w_seconds_next;
  logic [5:0]    w_timeout_next;

  logic w_in_set;
  logic w_any_btn;
  logic w_edit;
  logic w_qtick;
  logic w_sec_tick;
  logic w_timeout;

  assign w_in_set  = (r_state == ST_SET_H) || (r_state == ST_SET_M);
  assign w_any_btn = btn_mode | btn_up | btn_down;
  // An edit is accepted only in a set state. Mode takes priority over it, and
  // up together with down cancels out.
  assign w_edit    = w_in_set && !btn_mode && (btn_up ^ btn_down);
  assign w_qtick   = (r_pre == PRE_LAST);
  // An accepted edit restarts the prescaler, so it also swallows any second
  // boundary that would have landed in the same cycle.
  assign w_sec_tick = w_qtick && (r_quarter == 2'd3) && !w_edit;
  // A mode press in the same cycle wins over the timeout.
  assign w_timeout  = w_sec_tick && w_in_set && !btn_mode && (r_timeout >= TO_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (btn_mode) w_state_next = ST_SET_H;
      ST_SET_H: begin
        if (btn_mode)       w_state_next = ST_SET_M;
        else if (w_timeout) w_state_next = ST_RUN;
      end
      ST_SET_M: begin
        if (btn_mode || w_timeout) w_state_next = ST_RUN;
      end
      default:  w_state_next = ST_RUN;
    endcase
  end

  // ---------------- FSM outputs / datapath next values ----------------
  always_comb begin
    w_pre_next          = r_pre + PW'(1);
    w_quarter_next      = r_quarter;
    w_real_quarter_next = r_real_quarter;
    w_hours_next        = r_hours;
    w_minutes_next      = r_minutes;
    w_seconds_next      = r_seconds;
    w_timeout_next      = r_timeout;

    // Blink / prescaler. An edit restarts the quarter so the new digit shows solid.
    if (w_edit) begin
      w_pre_next          = '0;
      w_quarter_next      = 2'd0;
      w_real_quarter_next = 1'b1;
    end else if (w_qtick) begin
      w_pre_next          = '0;
      w_quarter_next      = r_quarter + 2'd1;
      w_real_quarter_next = ~r_real_quarter;
    end

    // Time of day advances only in RUN. The field limits use >= so that a
    // corrupted value still rolls back into range.
    if ((r_state == ST_RUN) && w_sec_tick) begin
      if (r_seconds >= 6'd59) begin
        w_seconds_next = 6'd0;
        if (r_minutes >= 6'd59) begin
          w_minutes_next = 6'd0;
          w_hours_next   = (r_hours >= 5'd23) ? 5'd0 : r_hours + 5'd1;
        end else begin
          w_minutes_next = r_minutes + 6'd1;
        end
      end else begin
        w_seconds_next = r_seconds + 6'd1;
      end
    end

    // Field edits wrap within their own field and never carry.
    if (w_edit && (r_state == ST_SET_H)) begin
      if (btn_up) w_hours_next = (r_hours >= 5'd23) ? 5'd0 : r_hours + 5'd1;
      else        w_hours_next = ((r_hours == 5'd0) || (r_hours > 5'd23)) ? 5'd23 : r_hours - 5'd1;
    end
    if (w_edit && (r_state == ST_SET_M)) begin
      if (btn_up) w_minutes_next = (r_minutes >= 6'd59) ? 6'd0 : r_minutes + 6'd1;
      else        w_minutes_next = ((r_minutes == 6'd0) || (r_minutes > 6'd59)) ? 6'd59 : r_minutes - 6'd1;
    end

    // Committing a new time restarts the seconds.
    if (((r_state == ST_SET_M) && btn_mode) || w_timeout) begin
      w_seconds_next = 6'd0;
    end

    // Inactivity counter: it runs only in the set states. Any button pulse
    // clears it, which also covers the entry into SET_H.
    if (w_any_btn || w_timeout || !w_in_set) begin
      w_timeout_next = 6'd0;
    end else if (w_sec_tick) begin
      w_timeout_next = r_timeout + 6'd1;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre          <= '0;
      r_quarter      <= 2'd0;
      r_real_quarter <= 1'b1;
      r_hours        <= 5'd0;
      r_minutes      <= 6'd0;
      r_seconds      <= 6'd0;
      r_sec_tick     <= 1'b0;
      r_timeout      <= 6'd0;
    end else begin
      r_pre          <= w_pre_next;
      r_quarter      <= w_quarter_next;
      r_real_quarter <= w_real_quarter_next;
      r_hours        <= w_hours_next;
      r_minutes      <= w_minutes_next;
      r_seconds      <= w_seconds_next;
      r_sec_tick     <= w_sec_tick;
      r_timeout      <= w_timeout_next;
    end
  end

  assign current_state = r_state;
  assign real_quarter  = r_real_quarter;
  assign hours         = r_hours;
  assign minutes       = r_minutes;
  assign seconds       = r_seconds;
  assign sec_tick      = r_sec_tick;

endmodule

// File: tb/tb_set24_time_controller.sv
// Directed testbench for set24_time_controller (CLK_HZ = 8, TIMEOUT_S = 3).
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_set24_time_controller;

  logic       clk;
  logic       reset_n;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [1:0] current_state;
  logic       real_quarter;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_tick;

  int checks   = 0;
  int failures = 0;

  set24_time_controller #(
    .CLK_HZ    (8),
    .TIMEOUT_S (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_mode      (btn_mode),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .current_state (current_state),
    .real_quarter  (real_quarter),
    .hours         (hours),
    .minutes       (minutes),
    .seconds       (seconds),
    .sec_tick      (sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("%s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge with the given buttons held; returns on the following falling edge.
  task automatic press(input logic m, input logic u, input logic d);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  // Reset is released on a falling edge, so the next rising edge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Waits for n sec_tick pulses within a cycle budget.
  task automatic wait_sec(input int n, input int budget, input string tag);
    int seen = 0;
    int cyc  = 0;
    while ((seen < n) && (cyc < budget)) begin
      @(negedge clk);
      cyc++;
      if (sec_tick) seen++;
    end
    check(tag, 32'(seen), 32'(n));
  endtask

  initial begin
    int ticks;
    int exp_h;
    reset_n  = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;

    // ---- reset values ----
    @(negedge clk);
    check("rst_state", 32'(current_state), 32'd0);
    check("rst_hours", 32'(hours), 32'd0);
    check("rst_min",   32'(minutes), 32'd0);
    check("rst_sec",   32'(seconds), 32'd0);
    check("rst_rq",    32'(real_quarter), 32'd1);
    check("rst_tick",  32'(sec_tick), 32'd0);
    reset_n = 1'b1;

    // ---- free run: 480 cycles -> 60 ticks, 00:01:00, blink every 2 cycles ----
    ticks = 0;
    for (int i = 1; i <= 480; i++) begin
      @(negedge clk);
      if (i <= 8) check($sformatf("rq_edge%0d", i), 32'(real_quarter), 32'(((i >> 1) & 1) == 0));
      if (sec_tick) ticks++;
    end
    check("run_ticks", 32'(ticks), 32'd60);
    check("run_hours", 32'(hours), 32'd0);
    check("run_min",   32'(minutes), 32'd1);
    check("run_sec",   32'(seconds), 32'd0);
    check("run_state", 32'(current_state), 32'd0);

    // ---- up/down in RUN ignored, no blink restart ----
    do_reset();
    @(negedge clk);                 // edge 1
    press(1'b0, 1'b1, 1'b0);        // edge 2: quarter tick drives blink low
    check("runup_rq",    32'(real_quarter), 32'd0);
    check("runup_hours", 32'(hours), 32'd0);
    check("runup_state", 32'(current_state), 32'd0);

    // ---- preload 23:59 via set mode, run to 23:59:58 and across midnight ----
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    check("pre_seth", 32'(current_state), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("pre_h23", 32'(hours), 32'd23);
    press(1'b1, 1'b0, 1'b0);
    check("pre_setm", 32'(current_state), 32'd2);
    press(1'b0, 1'b0, 1'b1);
    check("pre_m59", 32'(minutes), 32'd59);
    press(1'b1, 1'b0, 1'b0);
    check("pre_run", 32'(current_state), 32'd0);
    check("pre_sec0", 32'(seconds), 32'd0);
    wait_sec(58, 58 * 8 + 16, "wait58");
    check("t58_h", 32'(hours), 32'd23);
    check("t58_m", 32'(minutes), 32'd59);
    check("t58_s", 32'(seconds), 32'd58);
    wait_sec(1, 16, "wait59");
    check("t59_s", 32'(seconds), 32'd59);
    check("t59_h", 32'(hours), 32'd23);
    wait_sec(1, 16, "wait00");
    check("mid_h", 32'(hours), 32'd0);
    check("mid_m", 32'(minutes), 32'd0);
    check("mid_s", 32'(seconds), 32'd0);
    check("mid_state", 32'(current_state), 32'd0);
    wait_sec(3, 40, "wait3");
    check("run3_s", 32'(seconds), 32'd3);

    // ---- 25 down presses in SET_H, blink solid for 2 cycles after each ----
    press(1'b1, 1'b0, 1'b0);
    check("dn_seth", 32'(current_state), 32'd1);
    exp_h = 0;
    for (int k = 1; k <= 25; k++) begin
      press(1'b0, 1'b0, 1'b1);
      exp_h = (exp_h == 0) ? 23 : exp_h - 1;
      check($sformatf("dn%0d_h", k), 32'(hours), 32'(exp_h));
      check($sformatf("dn%0d_rq0", k), 32'(real_quarter), 32'd1);
      @(negedge clk);
      check($sformatf("dn%0d_rq1", k), 32'(real_quarter), 32'd1);
    end
    check("dn_sec_hold", 32'(seconds), 32'd3);

    // ---- minutes wrap 59 -> 0 without touching hours; commit clears seconds ----
    press(1'b1, 1'b0, 1'b0);
    check("wr_setm", 32'(current_state), 32'd2);
    press(1'b0, 1'b0, 1'b1);
    check("wr_m59", 32'(minutes), 32'd59);
    press(1'b0, 1'b1, 1'b0);
    check("wr_m0", 32'(minutes), 32'd0);
    check("wr_h", 32'(hours), 32'(exp_h));
    check("wr_sec_hold", 32'(seconds), 32'd3);
    press(1'b1, 1'b0, 1'b0);
    check("wr_run", 32'(current_state), 32'd0);
    check("wr_sec0", 32'(seconds), 32'd0);

    // ---- timeout: entry at edge 1, ticks at 8/16/24, return at edge 24 ----
    do_reset();
    press(1'b1, 1'b0, 1'b0);        // edge 1
    repeat (22) @(negedge clk);     // edge 23
    check("to_e23_state", 32'(current_state), 32'd1);
    @(negedge clk);                 // edge 24
    check("to_e24_state", 32'(current_state), 32'd0);
    check("to_e24_tick", 32'(sec_tick), 32'd1);
    check("to_e24_sec", 32'(seconds), 32'd0);

    // ---- press at edge 20 restarts prescaler and timeout: ticks 28/36/44 ----
    do_reset();
    press(1'b1, 1'b0, 1'b0);        // edge 1
    repeat (18) @(negedge clk);     // edge 19
    press(1'b0, 1'b1, 1'b0);        // edge 20
    check("tp_h1", 32'(hours), 32'd1);
    repeat (23) @(negedge clk);     // edge 43
    check("tp_e43_state", 32'(current_state), 32'd1);
    @(negedge clk);                 // edge 44
    check("tp_e44_state", 32'(current_state), 32'd0);
    check("tp_e44_tick", 32'(sec_tick), 32'd1);

    // ---- simultaneous buttons, then asynchronous reset in SET_M at 12:34 ----
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    repeat (12) press(1'b0, 1'b1, 1'b0);
    check("sim_h12", 32'(hours), 32'd12);
    press(1'b1, 1'b1, 1'b0);
    check("modeup_state", 32'(current_state), 32'd2);
    check("modeup_h", 32'(hours), 32'd12);
    repeat (34) press(1'b0, 1'b1, 1'b0);
    check("sim_m34", 32'(minutes), 32'd34);
    press(1'b0, 1'b1, 1'b1);
    check("updn_m", 32'(minutes), 32'd34);
    check("updn_h", 32'(hours), 32'd12);
    check("updn_state", 32'(current_state), 32'd2);

    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_state", 32'(current_state), 32'd0);
    check("arst_h", 32'(hours), 32'd0);
    check("arst_m", 32'(minutes), 32'd0);
    check("arst_s", 32'(seconds), 32'd0);
    check("arst_rq", 32'(real_quarter), 32'd1);
    check("arst_tick", 32'(sec_tick), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
